// File: rtl/id_ex_reg_pkg.sv
// Shared decode definitions for the ID/EX pipeline registers: widths, ALU
// command encodings and the packed instruction bundle passed between stages.
package id_ex_reg_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_IDX_W  = 4;
   localparam int SHIFT_OP_W = 12;
   localparam int SIMM_W     = 24;
   localparam int EXE_CMD_W  = 4;

   // CMP/TST reuse the SUB/AND datapath; loads and stores use the adder.
   localparam logic [EXE_CMD_W-1:0] EXE_MOV = 4'b0001;
   localparam logic [EXE_CMD_W-1:0] EXE_MVN = 4'b1001;
   localparam logic [EXE_CMD_W-1:0] EXE_ADD = 4'b0010;
   localparam logic [EXE_CMD_W-1:0] EXE_ADC = 4'b0011;
   localparam logic [EXE_CMD_W-1:0] EXE_SUB = 4'b0100;
   localparam logic [EXE_CMD_W-1:0] EXE_SBC = 4'b0101;
   localparam logic [EXE_CMD_W-1:0] EXE_AND = 4'b0110;
   localparam logic [EXE_CMD_W-1:0] EXE_ORR = 4'b0111;
   localparam logic [EXE_CMD_W-1:0] EXE_EOR = 4'b1000;
   localparam logic [EXE_CMD_W-1:0] EXE_CMP = 4'b0100;
   localparam logic [EXE_CMD_W-1:0] EXE_TST = 4'b0110;
   localparam logic [EXE_CMD_W-1:0] EXE_LDR = 4'b0010;
   localparam logic [EXE_CMD_W-1:0] EXE_STR = 4'b0010;

   typedef struct packed {
      logic [DATA_W-1:0]     pc;
      logic [DATA_W-1:0]     val_rn;
      logic [DATA_W-1:0]     val_rm;
      logic [REG_IDX_W-1:0]  dest;
      logic [REG_IDX_W-1:0]  src1;
      logic [REG_IDX_W-1:0]  src2;
      logic [EXE_CMD_W-1:0]  exe_cmd;
      logic                  mem_r_en;
      logic                  mem_w_en;
      logic                  wb_en;
      logic                  b;
      logic                  s;
      logic                  imm;
      logic [SHIFT_OP_W-1:0] shift_operand;
      logic [SIMM_W-1:0]     signed_imm_24;
      logic                  carry;
   } de_bundle_t;

   // Strip every control bit that could change architectural state.
   function automatic de_bundle_t kill_controls(de_bundle_t bnd);
      de_bundle_t res;
      res          = bnd;
      res.mem_r_en = 1'b0;
      res.mem_w_en = 1'b0;
      res.wb_en    = 1'b0;
      res.b        = 1'b0;
      res.s        = 1'b0;
      return res;
   endfunction

endpackage

// File: rtl/id_ex_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment and
// the count sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] count_reg;
   logic [W-1:0] count_next;

   always_comb begin
      count_next = count_reg;
      if (clr)
         count_next = '0;
      else if (inc && (count_reg != {W{1'b1}}))
         count_next = count_reg + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count_reg <= '0;
      else
         count_reg <= count_next;
   end

   assign count = count_reg;

endmodule

// File: rtl/id_ex_reg.sv
// ID->EX pipeline register with flush/freeze, bubble tagging, sticky
// read/write conflict detection and issue/bubble performance counters.
module id_ex_reg
   import id_ex_reg_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  freeze,
   input  logic                  clr_cnt,
   input  logic                  valid_in,
   input  logic [DATA_W-1:0]     pc_in,
   input  logic [DATA_W-1:0]     val_rn_in,
   input  logic [DATA_W-1:0]     val_rm_in,
   input  logic [REG_IDX_W-1:0]  dest_in,
   input  logic [REG_IDX_W-1:0]  src1_in,
   input  logic [REG_IDX_W-1:0]  src2_in,
   input  logic [EXE_CMD_W-1:0]  exe_cmd_in,
   input  logic                  mem_R_en_in,
   input  logic                  mem_W_en_in,
   input  logic                  wb_en_in,
   input  logic                  B_in,
   input  logic                  S_in,
   input  logic                  imm_in,
   input  logic [SHIFT_OP_W-1:0] shift_operand_in,
   input  logic [SIMM_W-1:0]     signed_imm_24_in,
   input  logic                  carry_in,
   output logic [DATA_W-1:0]     pc_out,
   output logic [DATA_W-1:0]     val_rn_out,
   output logic [DATA_W-1:0]     val_rm_out,
   output logic [REG_IDX_W-1:0]  dest_out,
   output logic [REG_IDX_W-1:0]  src1_out,
   output logic [REG_IDX_W-1:0]  src2_out,
   output logic [EXE_CMD_W-1:0]  exe_cmd_out,
   output logic                  mem_R_en_out,
   output logic                  mem_W_en_out,
   output logic                  wb_en_out,
   output logic                  B_out,
   output logic                  S_out,
   output logic                  imm_out,
   output logic [SHIFT_OP_W-1:0] shift_operand_out,
   output logic [SIMM_W-1:0]     signed_imm_24_out,
   output logic                  carry_out,
   output logic                  valid_out,
   output logic                  conflict_err,
   output logic [CNT_W-1:0]      issue_count,
   output logic [CNT_W-1:0]      bubble_count
);

   de_bundle_t bundle_in;
   de_bundle_t bundle_reg;
   de_bundle_t bundle_next;
   logic       valid_reg;
   logic       valid_next;
   logic       conflict_reg;
   logic       conflict_next;
   logic       load;
   logic       rw_clash;
   logic [1:0] cnt_inc;
   logic [CNT_W-1:0] cnt_val [2];

   always_comb begin
      bundle_in               = '0;
      bundle_in.pc            = pc_in;
      bundle_in.val_rn        = val_rn_in;
      bundle_in.val_rm        = val_rm_in;
      bundle_in.dest          = dest_in;
      bundle_in.src1          = src1_in;
      bundle_in.src2          = src2_in;
      bundle_in.exe_cmd       = exe_cmd_in;
      bundle_in.mem_r_en      = mem_R_en_in;
      bundle_in.mem_w_en      = mem_W_en_in;
      bundle_in.wb_en         = wb_en_in;
      bundle_in.b             = B_in;
      bundle_in.s             = S_in;
      bundle_in.imm           = imm_in;
      bundle_in.shift_operand = shift_operand_in;
      bundle_in.signed_imm_24 = signed_imm_24_in;
      bundle_in.carry         = carry_in;
   end

   assign load     = !flush && !freeze;
   assign rw_clash = valid_in && mem_R_en_in && mem_W_en_in;

   always_comb begin
      bundle_next   = bundle_reg;
      valid_next    = valid_reg;
      conflict_next = conflict_reg;
      if (flush) begin
         bundle_next = '0;
         valid_next  = 1'b0;
      end else if (load) begin
         valid_next = valid_in;
         if (!valid_in)
            bundle_next = kill_controls(bundle_in);
         else begin
            bundle_next = bundle_in;
            // A bundle asking to both read and write memory keeps the read.
            if (rw_clash) begin
               bundle_next.mem_w_en = 1'b0;
               conflict_next        = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bundle_reg   <= '0;
         valid_reg    <= 1'b0;
         conflict_reg <= 1'b0;
      end else begin
         bundle_reg   <= bundle_next;
         valid_reg    <= valid_next;
         conflict_reg <= conflict_next;
      end
   end

   assign cnt_inc[0] = load && valid_in;
   assign cnt_inc[1] = flush || (load && !valid_in);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         sat_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (cnt_inc[gi]),
            .clr   (clr_cnt),
            .count (cnt_val[gi])
         );
      end
   endgenerate

   assign issue_count       = cnt_val[0];
   assign bubble_count      = cnt_val[1];
   assign pc_out            = bundle_reg.pc;
   assign val_rn_out        = bundle_reg.val_rn;
   assign val_rm_out        = bundle_reg.val_rm;
   assign dest_out          = bundle_reg.dest;
   assign src1_out          = bundle_reg.src1;
   assign src2_out          = bundle_reg.src2;
   assign exe_cmd_out       = bundle_reg.exe_cmd;
   assign mem_R_en_out      = bundle_reg.mem_r_en;
   assign mem_W_en_out      = bundle_reg.mem_w_en;
   assign wb_en_out         = bundle_reg.wb_en;
   assign B_out             = bundle_reg.b;
   assign S_out             = bundle_reg.s;
   assign imm_out           = bundle_reg.imm;
   assign shift_operand_out = bundle_reg.shift_operand;
   assign signed_imm_24_out = bundle_reg.signed_imm_24;
   assign carry_out         = bundle_reg.carry;
   assign valid_out         = valid_reg;
   assign conflict_err      = conflict_reg;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: expected outputs are queued when stimulus is
// driven and popped/compared one cycle later.
module tb_id_ex_reg;
   import id_ex_reg_pkg::*;

   localparam int CNT_W = 4;
   localparam int CMAX  = 15;

   logic clk = 1'b0;
   logic rst, flush, freeze, clr_cnt, valid_in;
   logic [31:0] pc_in, val_rn_in, val_rm_in;
   logic [3:0]  dest_in, src1_in, src2_in, exe_cmd_in;
   logic        mem_R_en_in, mem_W_en_in, wb_en_in, B_in, S_in, imm_in, carry_in;
   logic [11:0] shift_operand_in;
   logic [23:0] signed_imm_24_in;

   logic [31:0] pc_out, val_rn_out, val_rm_out;
   logic [3:0]  dest_out, src1_out, src2_out, exe_cmd_out;
   logic        mem_R_en_out, mem_W_en_out, wb_en_out, B_out, S_out, imm_out, carry_out;
   logic [11:0] shift_operand_out;
   logic [23:0] signed_imm_24_out;
   logic        valid_out, conflict_err;
   logic [CNT_W-1:0] issue_count, bubble_count;

   typedef struct packed {
      de_bundle_t       b;
      logic             valid;
      logic             conf;
      logic [CNT_W-1:0] issue;
      logic [CNT_W-1:0] bubble;
   } exp_t;

   exp_t       sb[$];
   de_bundle_t m_b;
   logic       m_v, m_conf;
   int         m_issue, m_bubble;
   int         tests = 0;
   int         fails = 0;
   de_bundle_t obs_b;

   always #5 clk = ~clk;

   id_ex_reg #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .clr_cnt(clr_cnt),
      .valid_in(valid_in), .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
      .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .exe_cmd_in(exe_cmd_in),
      .mem_R_en_in(mem_R_en_in), .mem_W_en_in(mem_W_en_in), .wb_en_in(wb_en_in),
      .B_in(B_in), .S_in(S_in), .imm_in(imm_in), .shift_operand_in(shift_operand_in),
      .signed_imm_24_in(signed_imm_24_in), .carry_in(carry_in),
      .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
      .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out), .exe_cmd_out(exe_cmd_out),
      .mem_R_en_out(mem_R_en_out), .mem_W_en_out(mem_W_en_out), .wb_en_out(wb_en_out),
      .B_out(B_out), .S_out(S_out), .imm_out(imm_out), .shift_operand_out(shift_operand_out),
      .signed_imm_24_out(signed_imm_24_out), .carry_out(carry_out),
      .valid_out(valid_out), .conflict_err(conflict_err),
      .issue_count(issue_count), .bubble_count(bubble_count)
   );

   always_comb begin
      obs_b               = '0;
      obs_b.pc            = pc_out;
      obs_b.val_rn        = val_rn_out;
      obs_b.val_rm        = val_rm_out;
      obs_b.dest          = dest_out;
      obs_b.src1          = src1_out;
      obs_b.src2          = src2_out;
      obs_b.exe_cmd       = exe_cmd_out;
      obs_b.mem_r_en      = mem_R_en_out;
      obs_b.mem_w_en      = mem_W_en_out;
      obs_b.wb_en         = wb_en_out;
      obs_b.b             = B_out;
      obs_b.s             = S_out;
      obs_b.imm           = imm_out;
      obs_b.shift_operand = shift_operand_out;
      obs_b.signed_imm_24 = signed_imm_24_out;
      obs_b.carry         = carry_out;
   end

   function automatic de_bundle_t cur_in();
      de_bundle_t r;
      r = '0;
      r.pc = pc_in; r.val_rn = val_rn_in; r.val_rm = val_rm_in;
      r.dest = dest_in; r.src1 = src1_in; r.src2 = src2_in; r.exe_cmd = exe_cmd_in;
      r.mem_r_en = mem_R_en_in; r.mem_w_en = mem_W_en_in; r.wb_en = wb_en_in;
      r.b = B_in; r.s = S_in; r.imm = imm_in; r.shift_operand = shift_operand_in;
      r.signed_imm_24 = signed_imm_24_in; r.carry = carry_in;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      assert (act === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic clear_inputs();
      flush = 0; freeze = 0; clr_cnt = 0; valid_in = 0;
      pc_in = 0; val_rn_in = 0; val_rm_in = 0; dest_in = 0; src1_in = 0; src2_in = 0;
      exe_cmd_in = 0; mem_R_en_in = 0; mem_W_en_in = 0; wb_en_in = 0; B_in = 0; S_in = 0;
      imm_in = 0; shift_operand_in = 0; signed_imm_24_in = 0; carry_in = 0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".bundle"}, 256'(obs_b), 256'(0));
      chk({tag, ".valid"}, 256'(valid_out), 256'(0));
      chk({tag, ".conf"}, 256'(conflict_err), 256'(0));
      chk({tag, ".issue"}, 256'(issue_count), 256'(0));
      chk({tag, ".bubble"}, 256'(bubble_count), 256'(0));
   endtask

   task automatic model_reset();
      m_b = '0; m_v = 0; m_conf = 0; m_issue = 0; m_bubble = 0;
      sb.delete();
   endtask

   // Predict the post-edge outputs for the current inputs, clock once, compare.
   task automatic step(input string tag);
      exp_t e;
      de_bundle_t nb;
      logic ld;
      ld = !flush && !freeze;
      nb = cur_in();
      if (flush) begin
         m_b = '0; m_v = 0;
      end else if (ld) begin
         m_b = nb; m_v = valid_in;
         if (!valid_in) begin
            m_b.mem_r_en = 0; m_b.mem_w_en = 0; m_b.wb_en = 0; m_b.b = 0; m_b.s = 0;
         end else if (nb.mem_r_en && nb.mem_w_en) begin
            m_b.mem_w_en = 0; m_conf = 1;
         end
      end
      if (clr_cnt) begin
         m_issue = 0; m_bubble = 0;
      end else begin
         if (ld && valid_in && m_issue < CMAX) m_issue++;
         if ((flush || (ld && !valid_in)) && m_bubble < CMAX) m_bubble++;
      end
      e.b = m_b; e.valid = m_v; e.conf = m_conf;
      e.issue = CNT_W'(m_issue); e.bubble = CNT_W'(m_bubble);
      sb.push_back(e);
      @(posedge clk);
      #1;
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $error("FAIL %s.queue: got empty expected entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, ".bundle"}, 256'(obs_b), 256'(e.b));
         chk({tag, ".valid"}, 256'(valid_out), 256'(e.valid));
         chk({tag, ".conf"}, 256'(conflict_err), 256'(e.conf));
         chk({tag, ".issue"}, 256'(issue_count), 256'(e.issue));
         chk({tag, ".bubble"}, 256'(bubble_count), 256'(e.bubble));
      end
      $display("[TB] %s pc=%h valid=%b wb=%b memR=%b memW=%b conf=%b issue=%0d bubble=%0d",
               tag, pc_out, valid_out, wb_en_out, mem_R_en_out, mem_W_en_out,
               conflict_err, issue_count, bubble_count);
   endtask

   initial begin
      clear_inputs();
      rst = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_zero("por");
      rst = 1;

      // Reset asserted mid-stream after a valid load.
      valid_in = 1; pc_in = 32'h10; wb_en_in = 1; exe_cmd_in = EXE_MOV;
      step("load_pc10");
      chk("load_pc10.pc", 256'(pc_out), 256'(32'h10));
      rst = 0;
      #1;
      check_zero("rst_async");
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_zero("rst_hold");
      rst = 1;

      // First edge after release: normal ADD load.
      clear_inputs();
      valid_in = 1; exe_cmd_in = EXE_ADD; val_rm_in = 32'h0000_00F0; imm_in = 1;
      shift_operand_in = 12'h2FF; wb_en_in = 1; pc_in = 32'h14; dest_in = 4'd3;
      src1_in = 4'd1; src2_in = 4'd2; val_rn_in = 32'hCAFE_0001; carry_in = 1;
      signed_imm_24_in = 24'hABCDEF; S_in = 1;
      step("add_load");
      chk("add_load.shift", 256'(shift_operand_out), 256'(12'h2FF));
      chk("add_load.issue", 256'(issue_count), 256'(1));

      // Freeze holds, then flush overrides freeze.
      clear_inputs();
      valid_in = 1; pc_in = 32'h20; wb_en_in = 1; B_in = 1;
      step("load_pc20");
      freeze = 1;
      for (int i = 0; i < 2; i++) begin
         pc_in = $urandom; val_rn_in = $urandom; valid_in = 1'($urandom);
         step("freeze");
         chk("freeze.pc", 256'(pc_out), 256'(32'h20));
      end
      flush = 1;
      step("flush_freeze");
      chk("flush_freeze.bubble", 256'(bubble_count), 256'(1));
      chk("flush_freeze.pc", 256'(pc_out), 256'(0));

      // Bubble from ID keeps data but kills controls.
      clear_inputs();
      valid_in = 0; mem_W_en_in = 1; wb_en_in = 1; pc_in = 32'h44; B_in = 1; imm_in = 1;
      step("bubble");
      chk("bubble.pc", 256'(pc_out), 256'(32'h44));
      chk("bubble.memW", 256'(mem_W_en_out), 256'(0));

      // Read/write conflict: read wins, error stays sticky.
      clear_inputs();
      valid_in = 1; mem_R_en_in = 1; mem_W_en_in = 1; pc_in = 32'h50; exe_cmd_in = EXE_LDR;
      step("conflict");
      chk("conflict.memR", 256'(mem_R_en_out), 256'(1));
      chk("conflict.err", 256'(conflict_err), 256'(1));
      clear_inputs();
      for (int i = 0; i < 5; i++) begin
         valid_in = 1; pc_in = 32'h60 + 32'(i * 4); wb_en_in = 1;
         step("clean");
      end
      chk("sticky.err", 256'(conflict_err), 256'(1));

      // Saturation and clear-over-increment.
      for (int i = 0; i < 20; i++) begin
         pc_in = 32'h100 + 32'(i); val_rm_in = $urandom;
         step("sat");
      end
      chk("sat.issue", 256'(issue_count), 256'(CMAX));
      clr_cnt = 1; pc_in = 32'h200;
      step("clr_load");
      chk("clr_load.issue", 256'(issue_count), 256'(0));
      clr_cnt = 0; pc_in = 32'h204;
      step("post_clr");

      // Plain flush without freeze.
      flush = 1;
      step("flush");

      rst = 0;
      #1;
      check_zero("final_rst");
      model_reset();
      rst = 1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Pipeline register between the ID stage and the EX stage.
- Captures the decoded instruction bundle every cycle and presents it to EX: ALU command, operand values, the shifter/immediate fields consumed by the val2 generation logic, memory and writeback controls.
- Supports branch flush, pipeline freeze, a valid bit, sticky decode-conflict detection, and two saturating performance counters.

Parameters:
- CNT_W, 16, width of issue_count and bubble_count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  branch taken in EX; next captured bundle becomes a bubble.
- freeze  input  1  hold all stored fields (memory-stage stall).
- clr_cnt  input  1  synchronous clear of both counters.
- valid_in  input  1  ID holds a real instruction (0 = hazard bubble from ID).
- pc_in  input  32  PC of the instruction.
- val_rn_in, val_rm_in  input  32 each  register file read values.
- dest_in, src1_in, src2_in  input  4 each  register indices.
- exe_cmd_in  input  4  ALU command.
- mem_R_en_in, mem_W_en_in, wb_en_in, B_in, S_in, imm_in  input  1 each  decoded controls.
- shift_operand_in  input  12  shifter operand / offset field.
- signed_imm_24_in  input  24  branch offset.
- carry_in  input  1  status-register C flag sampled at decode.
- Outputs: one *_out per *_in field above, same width (carry_out for carry_in), plus:
  - valid_out  output  1
  - conflict_err  output  1  sticky.
  - issue_count, bubble_count  output  CNT_W  saturating counters.

Behaviour:
- Reset (rst=0, asynchronous): every output goes to 0 immediately, including valid_out, counters and conflict_err. Outputs stay at 0 while rst is low.
- Latency: one cycle. All outputs are registers; no combinational input-to-output path.
- Per-edge action priority: flush > freeze > load.
  - flush=1: valid_out, wb_en_out, mem_R_en_out, mem_W_en_out, B_out and S_out go to 0. All data fields (pc, vals, indices, exe_cmd, imm, shift_operand, signed_imm_24, carry) go to 0. Flush overrides a simultaneous freeze.
  - freeze=1, flush=0: all stored fields hold their values, including valid_out. Counters do not change.
  - Otherwise (load): every field is captured from its input.
  - Load with valid_in=0: captured data fields are kept, but valid_out and the control bits listed under flush are forced to 0. This guarantees a bubble never writes memory or registers.
- Counters, evaluated on the same edge as the action above:
  - clr_cnt=1: both counters go to 0. This has priority over any increment on the same edge.
  - Load with valid_in=1: issue_count +1.
  - Flush, or load with valid_in=0: bubble_count +1.
  - Each counter saturates at 2^CNT_W-1 and never wraps.
- conflict_err:
  - Set on a load edge when valid_in=1 and mem_R_en_in=mem_W_en_in=1.
  - That bundle is still captured, but mem_W_en_out is forced to 0 (the read wins).
  - Once set, it clears only on reset.
- Reset deasserting mid-stream: the first edge after release performs a normal load. No bundle captured before reset is retained.

Decomposition:
- Shared package holds:
  - the exe_cmd encodings (MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR, CMP, TST, LDR, STR);
  - field widths: REG_IDX_W=4, SHIFT_OP_W=12, SIMM_W=24, DATA_W=32;
  - a packed bundle typedef shared with the IF/ID and EX/MEM registers.
- One natural sub-module: sat_counter (width parameter; inputs inc and clr), instantiated twice.

Test Plan:
- Reset mid-load: hold rst=0 for 3 cycles after loading valid bundle pc=0x10 -> all outputs 0 within the reset cycle; first edge after release loads the new bundle.
- Normal load: valid_in=1, exe_cmd=ADD, val_rm_in=0x0000_00F0, imm_in=1, shift_operand_in=0x2FF, wb_en=1 -> same values on outputs one edge later; valid_out=1; issue_count=1.
- Freeze then flush: load pc=0x20, then freeze=1 for 2 cycles with changing inputs -> outputs hold pc=0x20. Next, assert flush=1 together with freeze=1 -> valid_out=0, wb_en_out=0, pc_out=0; bubble_count=1.
- Bubble load: valid_in=0 with mem_W_en_in=1, wb_en_in=1, pc_in=0x44 -> pc_out=0x44, mem_W_en_out=0, wb_en_out=0, valid_out=0; bubble_count increments.
- Conflict: valid_in=1, mem_R_en_in=mem_W_en_in=1 -> mem_R_en_out=1, mem_W_en_out=0, conflict_err=1. conflict_err stays 1 after 5 clean loads and clears only on rst.
- Saturation: CNT_W=4, 20 consecutive valid loads -> issue_count stops at 15. clr_cnt=1 together with a valid load -> issue_count=0 on that edge.
